// File: rtl/shift_reg_pkg.sv
// Shared definitions for the shift register bank: operation encoding and its width.
package shift_reg_pkg;

  localparam int MODE_W = 3;

  // Codes 6 and 7 are reserved and decode to hold in the bank.
  typedef enum logic [MODE_W-1:0] {
    HOLD     = 3'd0,
    LOAD     = 3'd1,
    SHIFT_UP = 3'd2,
    SHIFT_DN = 3'd3,
    ROT_UP   = 3'd4,
    ROT_DN   = 3'd5
  } mode_e;

endpackage

// File: rtl/shift_reg_stage.sv
// One WIDTH-bit storage stage: async active-low reset and sync clear to RST_VAL, enabled load of d.
module shift_reg_stage #(
  parameter int               WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   q <= RST_VAL;
    else if (clr) q <= RST_VAL;
    else if (en)  q <= d;
  end

endmodule

// File: rtl/shift_reg_bank.sv
// Multi-stage register bank with hold, parallel load, bidirectional shift and rotate,
// plus a saturating count of stages holding written data.
module shift_reg_bank
  import shift_reg_pkg::*;
#(
  parameter int               WIDTH   = 8,
  parameter int               DEPTH   = 4,
  parameter logic [WIDTH-1:0] RST_VAL = '0,
  localparam int              COUNT_W = $clog2(DEPTH + 1)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic                     en,
  input  logic [MODE_W-1:0]        mode,
  input  logic [WIDTH-1:0]         ser_in,
  input  logic [WIDTH*DEPTH-1:0]   par_in,
  output logic [WIDTH*DEPTH-1:0]   q,
  output logic [WIDTH-1:0]         ser_out_lo,
  output logic [WIDTH-1:0]         ser_out_hi,
  output logic [COUNT_W-1:0]       count,
  output logic                     full
);

  localparam logic [COUNT_W-1:0] DEPTH_CNT = COUNT_W'(DEPTH);

  mode_e              op;
  logic [WIDTH-1:0]   stage_q [DEPTH];
  logic [WIDTH-1:0]   stage_d [DEPTH];
  logic [COUNT_W-1:0] count_q;
  logic [COUNT_W-1:0] count_d;

  assign op = mode_e'(mode);

  // Stage next-value mux; hold and the reserved codes keep every stage as is.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) stage_d[i] = stage_q[i];
    case (op)
      LOAD: begin
        for (int i = 0; i < DEPTH; i++) stage_d[i] = par_in[i*WIDTH +: WIDTH];
      end
      SHIFT_UP: begin
        stage_d[0] = ser_in;
        for (int i = 1; i < DEPTH; i++) stage_d[i] = stage_q[i-1];
      end
      SHIFT_DN: begin
        for (int i = 0; i < DEPTH - 1; i++) stage_d[i] = stage_q[i+1];
        stage_d[DEPTH-1] = ser_in;
      end
      ROT_UP: begin
        stage_d[0] = stage_q[DEPTH-1];
        for (int i = 1; i < DEPTH; i++) stage_d[i] = stage_q[i-1];
      end
      ROT_DN: begin
        for (int i = 0; i < DEPTH - 1; i++) stage_d[i] = stage_q[i+1];
        stage_d[DEPTH-1] = stage_q[0];
      end
      default: ;
    endcase
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_stage
    shift_reg_stage #(
      .WIDTH   (WIDTH),
      .RST_VAL (RST_VAL)
    ) u_stage (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (clr),
      .en    (en),
      .d     (stage_d[g]),
      .q     (stage_q[g])
    );
    assign q[g*WIDTH +: WIDTH] = stage_q[g];
  end

  // Written-stage count saturates at DEPTH; rotates move data but never change it.
  always_comb begin
    count_d = count_q;
    if (en) begin
      case (op)
        LOAD:               count_d = DEPTH_CNT;
        SHIFT_UP, SHIFT_DN: if (count_q != DEPTH_CNT) count_d = count_q + 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   count_q <= '0;
    else if (clr) count_q <= '0;
    else          count_q <= count_d;
  end

  assign ser_out_lo = stage_q[0];
  assign ser_out_hi = stage_q[DEPTH-1];
  assign count      = count_q;
  assign full       = (count_q == DEPTH_CNT);

endmodule

// File: tb/tb_shift_reg_bank.sv
// Scoreboard bench for shift_reg_bank: queue-based reference model, directed scenarios, random ops.
`timescale 1ns/1ps
module tb_shift_reg_bank;
  import shift_reg_pkg::*;

  localparam int W = 8;
  localparam int D = 4;
  localparam int EW = 1 + 3 + W + W + W*D;

  logic           clk = 1'b0;
  logic           rst_n = 1'b1;
  logic           clr = 1'b0;
  logic           en = 1'b0;
  logic [2:0]     mode = 3'd0;
  logic [W-1:0]   ser_in = '0;
  logic [W*D-1:0] par_in = '0;
  logic [W*D-1:0] q;
  logic [W-1:0]   ser_out_lo, ser_out_hi;
  logic [2:0]     count;
  logic           full;

  logic [EW-1:0] exp_q[$];
  logic [W-1:0]  m[$];
  int            mcnt;
  int            n_vec = 0;
  int            n_bad = 0;

  shift_reg_bank #(.WIDTH(W), .DEPTH(D), .RST_VAL(8'h00)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .en(en), .mode(mode),
    .ser_in(ser_in), .par_in(par_in), .q(q),
    .ser_out_lo(ser_out_lo), .ser_out_hi(ser_out_hi),
    .count(count), .full(full)
  );

  always #5 clk = ~clk;

  function automatic void model_reset();
    m.delete();
    for (int i = 0; i < D; i++) m.push_back(8'h00);
    mcnt = 0;
  endfunction

  function automatic logic [EW-1:0] model_pack();
    logic [W*D-1:0] qv;
    for (int i = 0; i < D; i++) qv[i*W +: W] = m[i];
    return {(mcnt == D), 3'(mcnt), m[D-1], m[0], qv};
  endfunction

  // Reference behaviour: stage 0 is the front of the queue.
  function automatic void model_step(logic c, logic e, logic [2:0] md,
                                     logic [W-1:0] s, logic [W*D-1:0] p);
    logic [W-1:0] t;
    if (c) begin
      model_reset();
      return;
    end
    if (!e) return;
    case (md)
      3'd1: begin
        m.delete();
        for (int i = 0; i < D; i++) m.push_back(p[i*W +: W]);
        mcnt = D;
      end
      3'd2: begin m.push_front(s); t = m.pop_back();  mcnt = (mcnt + 1 > D) ? D : mcnt + 1; end
      3'd3: begin m.push_back(s);  t = m.pop_front(); mcnt = (mcnt + 1 > D) ? D : mcnt + 1; end
      3'd4: begin t = m.pop_back();  m.push_front(t); end
      3'd5: begin t = m.pop_front(); m.push_back(t); end
      default: ;
    endcase
  endfunction

  task automatic drive(logic c, logic e, logic [2:0] md, logic [W-1:0] s, logic [W*D-1:0] p);
    @(negedge clk);
    clr = c; en = e; mode = md; ser_in = s; par_in = p;
    model_step(c, e, md, s, p);
    exp_q.push_back(model_pack());
  endtask

  task automatic settle();
    @(posedge clk);
    #3;
  endtask

  task automatic check_now(string name, logic [W*D-1:0] exp_qv, logic [2:0] exp_cnt);
    n_vec++;
    if (q !== exp_qv || count !== exp_cnt) begin
      n_bad++;
      $display("FAIL %s: got q=%h count=%0d, expected q=%h count=%0d", name, q, count, exp_qv, exp_cnt);
    end
  endtask

  // Monitor: every edge yields new state; compare against the oldest pending expectation.
  always @(posedge clk) begin
    logic [EW-1:0] e, a;
    #2;
    if (rst_n && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = {full, count, ser_out_hi, ser_out_lo, q};
      n_vec++;
      if (a !== e) begin
        n_bad++;
        $display("FAIL state: got full=%b count=%0d hi=%h lo=%h q=%h, expected full=%b count=%0d hi=%h lo=%h q=%h",
                 a[EW-1], a[EW-2 -: 3], a[EW-5 -: W], a[EW-5-W -: W], a[W*D-1:0],
                 e[EW-1], e[EW-2 -: 3], e[EW-5 -: W], e[EW-5-W -: W], e[W*D-1:0]);
      end
    end
  end

  task automatic reset_pulse(string name);
    #3;
    rst_n = 1'b0;
    #0.5;
    check_now(name, '0, 3'd0);
    model_reset();
    #0.5;
    rst_n = 1'b1;
  endtask

  initial begin
    model_reset();
    #2 rst_n = 1'b0;
    #1 check_now("reset_immediate", '0, 3'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 3; i++) drive(0, 0, 3'd2, 8'hFF, '1);

    drive(0, 1, 3'd2, 8'hA1, '0);
    drive(0, 1, 3'd2, 8'hB2, '0);
    drive(0, 1, 3'd2, 8'hC3, '0);
    drive(0, 1, 3'd2, 8'hD4, '0);
    drive(0, 1, 3'd2, 8'hE5, '0);
    settle();
    check_now("shift_up_sat", 32'hB2C3D4E5, 3'd4);

    drive(0, 1, 3'd1, 8'h00, 32'h44332211);
    drive(0, 1, 3'd4, 8'h99, 32'h0);
    settle();
    check_now("rot_up", 32'h33221144, 3'd4);
    drive(0, 1, 3'd5, 8'h99, 32'h0);
    drive(0, 1, 3'd5, 8'h99, 32'h0);
    settle();
    check_now("rot_dn_twice", 32'h11443322, 3'd4);

    drive(1, 0, 3'd0, 8'h00, '0);
    drive(0, 1, 3'd3, 8'h5A, '0);
    settle();
    check_now("shift_dn_empty", 32'h5A000000, 3'd1);
    drive(0, 1, 3'd6, 8'h77, 32'hDEADBEEF);
    drive(0, 1, 3'd7, 8'h77, 32'hDEADBEEF);
    settle();
    check_now("reserved_hold", 32'h5A000000, 3'd1);

    drive(0, 1, 3'd1, 8'h00, 32'h12345678);
    drive(1, 1, 3'd1, 8'h00, 32'hFFFFFFFF);
    settle();
    check_now("clr_over_load", 32'h0, 3'd0);
    drive(0, 1, 3'd1, 8'h00, 32'hCAFEF00D);
    drive(0, 0, 3'd2, 8'h33, '0);
    settle();
    check_now("en_low_hold", 32'hCAFEF00D, 3'd4);

    drive(1, 0, 3'd0, 8'h00, '0);
    drive(0, 1, 3'd2, 8'h01, '0);
    drive(0, 1, 3'd2, 8'h02, '0);
    @(posedge clk);
    reset_pulse("reset_mid_shift");
    drive(0, 1, 3'd2, 8'h03, '0);
    settle();
    check_now("resume_after_reset", 32'h00000003, 3'd1);

    for (int i = 0; i < 300; i++) begin
      drive(($urandom_range(0, 19) == 0), ($urandom_range(0, 4) != 0),
            3'($urandom_range(0, 7)), W'($urandom), (W*D)'({$urandom}));
      if (i == 150) begin
        @(posedge clk);
        reset_pulse("reset_random");
      end
    end

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    #4;
    if (exp_q.size() > 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL drain: got %0d pending, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
